// File: rtl/md_tracker_pkg.sv
// Shared types for the multiply/divide tracker: op-kind encoding and the
// completion-queue entry layout at default widths.
package md_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

  localparam int unsigned MD_REG_W  = 5;
  localparam int unsigned MD_DATA_W = 32;

  typedef struct packed {
    logic [MD_REG_W-1:0]  rd;
    logic [MD_DATA_W-1:0] data;
    logic                 exc;
  } md_cq_entry_t;

  function automatic int unsigned md_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_tracker_if.sv
// Issue, query, datapath-result and writeback signals of md_tracker.
interface md_tracker_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              issue_valid;
  logic              issue_is_div;
  logic [REG_W-1:0]  issue_rd;
  logic              issue_ready;
  logic              flush;
  logic [REG_W-1:0]  q_rs;
  logic [REG_W-1:0]  q_rt;
  logic [REG_W-1:0]  q_rd;
  logic              hazard;
  logic              res_take;
  logic [DATA_W-1:0] res_data;
  logic              res_exc;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exc;
  logic              wb_ready;

  modport master (
    output issue_valid, issue_is_div, issue_rd, flush, q_rs, q_rt, q_rd,
           res_data, res_exc, wb_ready,
    input  issue_ready, hazard, res_take, wb_valid, wb_rd, wb_data, wb_exc
  );

  modport slave (
    input  issue_valid, issue_is_div, issue_rd, flush, q_rs, q_rt, q_rd,
           res_data, res_exc, wb_ready,
    output issue_ready, hazard, res_take, wb_valid, wb_rd, wb_data, wb_exc
  );
endinterface

// File: rtl/md_tracker_cq.sv
// md_cq: synchronous FIFO for finished mul/div results, with per-entry valid
// and rd outputs so the owner can run hazard compares over queued ops.
module md_cq
  import md_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned REG_W   = MD_REG_W,
  parameter type         entry_t = md_cq_entry_t
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  entry_t                      push_entry,
  input  logic                        pop,
  output entry_t                      head,
  output logic                        empty,
  output logic [DEPTH-1:0]            ent_vld,
  output logic [DEPTH-1:0][REG_W-1:0] ent_rd
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full;
  logic            push_ok;
  logic            pop_ok;
  logic [AW-1:0]   offset;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    offset   = '0;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    head = mem_q[rd_ptr_q];
    // A slot is live when its distance from the read pointer is below the occupancy.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset     = AW'(i) - rd_ptr_q;
      ent_vld[i] = ({1'b0, offset} < count_q);
      ent_rd[i]  = mem_q[i].rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/md_tracker.sv
// Mul/div in-flight tracker: latency-aligned shift pipeline of {valid, rd},
// credit-based issue control, decode hazard compare and a completion queue.
module md_tracker
  import md_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MUL_LAT  = 16,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned CQ_DEPTH = 4
) (
  input logic         clock,
  input logic         reset,
  md_tracker_if.slave bus
);
  localparam int unsigned L       = md_max(MUL_LAT, DIV_LAT);
  localparam int unsigned IW      = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned INS_MUL = L - MUL_LAT;
  localparam int unsigned INS_DIV = L - DIV_LAT;
  localparam int unsigned PRE_MUL = (INS_MUL > 0) ? INS_MUL - 1 : 0;
  localparam int unsigned PRE_DIV = (INS_DIV > 0) ? INS_DIV - 1 : 0;
  localparam int unsigned CW      = $clog2(CQ_DEPTH + 1);

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              exc;
  } entry_t;

  logic [L-1:0]                   vld_q, vld_d;
  logic [L-1:0][REG_W-1:0]        rd_q, rd_d;
  logic [CW-1:0]                  credit_q, credit_d;
  logic [CW-1:0]                  killed;
  md_op_e                         op_kind;
  logic [IW-1:0]                  ins_idx;
  logic                           collision;
  logic                           issue_ready;
  logic                           issue_acc;
  logic                           res_take;
  logic                           pop;
  logic                           hazard;
  entry_t                         push_entry;
  entry_t                         head;
  logic                           cq_empty;
  logic [CQ_DEPTH-1:0]            cq_vld;
  logic [CQ_DEPTH-1:0][REG_W-1:0] cq_rd;

  function automatic logic rd_hit(input logic [REG_W-1:0] rd,
                                  input logic [REG_W-1:0] qs,
                                  input logic [REG_W-1:0] qt,
                                  input logic [REG_W-1:0] qd);
    return (rd != '0) && ((rd == qs) || (rd == qt) || (rd == qd));
  endfunction

  always_comb begin
    op_kind = md_op_e'(bus.issue_is_div);
    // The stage just upstream of the insertion point would land on it this edge.
    if (op_kind == OP_DIV) begin
      ins_idx   = IW'(INS_DIV);
      collision = (INS_DIV != 0) && vld_q[PRE_DIV];
    end else begin
      ins_idx   = IW'(INS_MUL);
      collision = (INS_MUL != 0) && vld_q[PRE_MUL];
    end

    issue_ready = reset && (credit_q != '0) && !collision && !bus.flush;
    issue_acc   = bus.issue_valid && issue_ready;
    res_take    = vld_q[L-1];
    pop         = !cq_empty && bus.wb_ready;

    killed = '0;
    for (int unsigned i = 0; i + 1 < L; i++) begin
      if (vld_q[i]) killed = killed + CW'(1);
    end

    vld_d = '0;
    rd_d  = rd_q;
    for (int unsigned i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1] && !bus.flush;
      rd_d[i]  = rd_q[i-1];
    end
    if (issue_acc) begin
      vld_d[ins_idx] = 1'b1;
      rd_d[ins_idx]  = bus.issue_rd;
    end

    credit_d = credit_q - CW'(issue_acc) + CW'(pop) + (bus.flush ? killed : '0);

    hazard = 1'b0;
    for (int unsigned i = 0; i < L; i++) begin
      if (vld_q[i] && rd_hit(rd_q[i], bus.q_rs, bus.q_rt, bus.q_rd)) hazard = 1'b1;
    end
    for (int unsigned i = 0; i < CQ_DEPTH; i++) begin
      if (cq_vld[i] && rd_hit(cq_rd[i], bus.q_rs, bus.q_rt, bus.q_rd)) hazard = 1'b1;
    end

    push_entry.rd   = rd_q[L-1];
    push_entry.data = bus.res_data;
    push_entry.exc  = bus.res_exc;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q    <= '0;
      rd_q     <= '0;
      credit_q <= CW'(CQ_DEPTH);
    end else begin
      vld_q    <= vld_d;
      rd_q     <= rd_d;
      credit_q <= credit_d;
    end
  end

  md_cq #(
    .DEPTH   (CQ_DEPTH),
    .REG_W   (REG_W),
    .entry_t (entry_t)
  ) u_cq (
    .clk        (clock),
    .rst_n      (reset),
    .push       (res_take),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .empty      (cq_empty),
    .ent_vld    (cq_vld),
    .ent_rd     (cq_rd)
  );

  assign bus.issue_ready = issue_ready;
  assign bus.hazard      = hazard;
  assign bus.res_take    = res_take;
  assign bus.wb_valid    = !cq_empty;
  assign bus.wb_rd       = head.rd;
  assign bus.wb_data     = head.data;
  assign bus.wb_exc      = head.exc;

endmodule
